// File: rtl/fu_issue_pkg.sv
// Shared payload type and sizing helper for the per-FU issue queue.
// Field widths come from the core-wide width macros; defaults are provided here.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 6
`endif

package fu_issue_pkg;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic       use_imm;
    } control_t;

    typedef struct packed {
        logic [`REG_VAL_WIDTH-1:0]          src1_reg_val;
        logic [`REG_VAL_WIDTH-1:0]          src2_reg_val;
        logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_reg_addr;
        control_t                           control;
        logic [`REG_VAL_WIDTH-1:0]          immediate;
        logic [`INST_ADDR_WIDTH-1:0]        pc;
        logic [`ROB_SIZE_WIDTH-1:0]         new_inst_tag;
    } fu_issue_entry_t;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fu_issue_if.sv
// RS-side and FU-side valid/ready bundles for all FU channels.
// master = RS/FU environment, slave = the issue queue.
interface fu_issue_if #(
    parameter int NUM_OF_FU = 4
);
    import fu_issue_pkg::*;

    logic            [NUM_OF_FU-1:0] in_valid;
    logic            [NUM_OF_FU-1:0] in_ready;
    fu_issue_entry_t [NUM_OF_FU-1:0] in_entry;
    logic            [NUM_OF_FU-1:0] out_valid;
    logic            [NUM_OF_FU-1:0] out_ready;
    fu_issue_entry_t [NUM_OF_FU-1:0] out_entry;

    modport master (
        output in_valid, in_entry, out_ready,
        input  in_ready, out_valid, out_entry
    );

    modport slave (
        input  in_valid, in_entry, out_ready,
        output in_ready, out_valid, out_entry
    );

endinterface

// File: rtl/fu_issue_fifo.sv
// Single-channel DEPTH-entry issue FIFO with synchronous flush.
// Optional stall/issue counters are built when FU_ISSUE_PERF_EN is defined.
module fu_issue_fifo
    import fu_issue_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int OCC_W = occ_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  fu_issue_entry_t  in_entry,
    output logic             out_valid,
    input  logic             out_ready,
    output fu_issue_entry_t  out_entry,
    output logic [OCC_W-1:0] occupancy
`ifdef FU_ISSUE_PERF_EN
    ,
    output logic [31:0]      stall_cnt,
    output logic [31:0]      issue_cnt
`endif
);

    localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    fu_issue_entry_t  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] count_reg;
    logic             push;
    logic             pop;

    // Ready is derived from the count register only, never from out_ready.
    assign in_ready  = (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_entry = mem[rd_ptr_reg];
    assign occupancy = count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + OCC_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - OCC_W'(1);
            end
        end
    end

    // Payload storage is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

`ifdef FU_ISSUE_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] issue_cnt_reg;

    // Counters survive flush; only reset clears them, and both saturate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_reg <= '0;
            issue_cnt_reg <= '0;
        end else begin
            if (in_valid && !in_ready && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (pop && !flush && (issue_cnt_reg != '1)) begin
                issue_cnt_reg <= issue_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign issue_cnt = issue_cnt_reg;
`endif

endmodule

// File: rtl/fu_issue_queue.sv
// Issue buffering between the RS and NUM_OF_FU functional units: one independent FIFO per FU.
// Define FU_ISSUE_PERF_EN to add per-channel stall_cnt/issue_cnt outputs.
module fu_issue_queue
    import fu_issue_pkg::*;
#(
    parameter  int NUM_OF_FU = 4,
    parameter  int DEPTH     = 2,
    localparam int OCC_W     = occ_width(DEPTH)
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            flush,
    fu_issue_if.slave                       bus,
    output logic [NUM_OF_FU-1:0][OCC_W-1:0] occupancy,
    output logic                            any_pending
`ifdef FU_ISSUE_PERF_EN
    ,
    output logic [NUM_OF_FU-1:0][31:0]      stall_cnt,
    output logic [NUM_OF_FU-1:0][31:0]      issue_cnt
`endif
);

    generate
        for (genvar gi = 0; gi < NUM_OF_FU; gi++) begin : g_chan
            fu_issue_fifo #(
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset_n   (reset_n),
                .flush     (flush),
                .in_valid  (bus.in_valid[gi]),
                .in_ready  (bus.in_ready[gi]),
                .in_entry  (bus.in_entry[gi]),
                .out_valid (bus.out_valid[gi]),
                .out_ready (bus.out_ready[gi]),
                .out_entry (bus.out_entry[gi]),
                .occupancy (occupancy[gi])
`ifdef FU_ISSUE_PERF_EN
                ,
                .stall_cnt (stall_cnt[gi]),
                .issue_cnt (issue_cnt[gi])
`endif
            );
        end
    endgenerate

    assign any_pending = |bus.out_valid;

endmodule

// File: tb/tb_fu_issue_queue.sv
// Bench for fu_issue_queue: vector table plus directed corner sequences, with a
// per-channel scoreboard checking order, occupancy and handshakes every cycle.
module tb_fu_issue_queue;
    import fu_issue_pkg::*;

    localparam int NF = 4;
    localparam int DP = 3;
    localparam int OW = occ_width(DP);

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic [NF-1:0][OW-1:0] occupancy;
    logic any_pending;
`ifdef FU_ISSUE_PERF_EN
    logic [NF-1:0][31:0] stall_cnt;
    logic [NF-1:0][31:0] issue_cnt;
`endif

    fu_issue_if #(.NUM_OF_FU(NF)) bus ();

    fu_issue_queue #(
        .NUM_OF_FU (NF),
        .DEPTH     (DP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .bus         (bus),
        .occupancy   (occupancy),
        .any_pending (any_pending)
`ifdef FU_ISSUE_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .issue_cnt   (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    fu_issue_entry_t exp_q [NF][$];

    typedef struct packed {
        logic [NF-1:0]         iv;
        logic [NF-1:0]         orr;
        logic                  fl;
        logic [NF-1:0]         ev;
        logic [NF-1:0][OW-1:0] eocc;
    } vec_t;

    vec_t vecs [12];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void chk_entry(input string name, input fu_issue_entry_t act, input fu_issue_entry_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got tag %0d pc %0h expected tag %0d pc %0h",
                     name, act.new_inst_tag, act.pc, exp.new_inst_tag, exp.pc);
        end
    endfunction

    function automatic fu_issue_entry_t mk_entry(input int tag, input int pc);
        fu_issue_entry_t e;
        e.src1_reg_val = $urandom;
        e.src2_reg_val = $urandom;
        e.dst_reg_addr = `PHYSICAL_REG_NUM_WIDTH'(tag);
        e.control      = control_t'(8'(tag * 3));
        e.immediate    = $urandom;
        e.pc           = `INST_ADDR_WIDTH'(pc);
        e.new_inst_tag = `ROB_SIZE_WIDTH'(tag);
        return e;
    endfunction

    function automatic vec_t mkv(input logic [NF-1:0] iv, input logic [NF-1:0] orr, input logic fl,
                                 input logic [NF-1:0] ev, input int o3, input int o2, input int o1, input int o0);
        vec_t v;
        v.iv      = iv;
        v.orr     = orr;
        v.fl      = fl;
        v.ev      = ev;
        v.eocc[3] = OW'(o3);
        v.eocc[2] = OW'(o2);
        v.eocc[1] = OW'(o1);
        v.eocc[0] = OW'(o0);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = '0;
        bus.out_ready = '0;
        bus.in_entry  = '0;
        flush         = 1'b0;
    endtask

    task automatic set_push(input int ch, input int tag);
        bus.in_valid[ch] = 1'b1;
        bus.in_entry[ch] = mk_entry(tag, 32'h1000 + tag * 4);
    endtask

    // Scoreboard: predicts each edge from the model's own fill level, then retires.
    always @(negedge clk) begin : monitor
        int   sz;
        logic any_exp;
        if (!reset_n) begin
            for (int i = 0; i < NF; i++) exp_q[i].delete();
        end else begin
            any_exp = 1'b0;
            for (int i = 0; i < NF; i++) begin
                sz = exp_q[i].size();
                any_exp = any_exp | (sz != 0);
                chk($sformatf("mon_occ[%0d]", i), 32'(occupancy[i]), 32'(sz));
                chk($sformatf("mon_out_valid[%0d]", i), 32'(bus.out_valid[i]), 32'(sz != 0));
                chk($sformatf("mon_in_ready[%0d]", i), 32'(bus.in_ready[i]), 32'(sz < DP));
                if (flush) begin
                    exp_q[i].delete();
                end else begin
                    if (sz != 0 && bus.out_ready[i]) begin
                        chk_entry($sformatf("mon_pop[%0d]", i), bus.out_entry[i], exp_q[i][0]);
                        void'(exp_q[i].pop_front());
                    end
                    if (sz < DP && bus.in_valid[i]) exp_q[i].push_back(bus.in_entry[i]);
                end
            end
            chk("mon_any_pending", 32'(any_pending), 32'(any_exp));
        end
    end

    initial begin
        //           in_valid  out_ready fl  exp_ov   occ3..occ0
        vecs[0]  = mkv(4'b0001, 4'b0000, 0, 4'b0001, 0, 0, 0, 1);
        vecs[1]  = mkv(4'b0011, 4'b0000, 0, 4'b0011, 0, 0, 1, 2);
        vecs[2]  = mkv(4'b0001, 4'b0001, 0, 4'b0011, 0, 0, 1, 2);
        vecs[3]  = mkv(4'b0000, 4'b0011, 0, 4'b0001, 0, 0, 0, 1);
        vecs[4]  = mkv(4'b1100, 4'b0001, 0, 4'b1100, 1, 1, 0, 0);
        vecs[5]  = mkv(4'b0100, 4'b1000, 0, 4'b0100, 0, 2, 0, 0);
        vecs[6]  = mkv(4'b0100, 4'b0000, 0, 4'b0100, 0, 3, 0, 0);
        vecs[7]  = mkv(4'b0100, 4'b0000, 0, 4'b0100, 0, 3, 0, 0);
        vecs[8]  = mkv(4'b0100, 4'b0100, 1, 4'b0000, 0, 0, 0, 0);
        vecs[9]  = mkv(4'b1111, 4'b1111, 0, 4'b1111, 1, 1, 1, 1);
        vecs[10] = mkv(4'b1111, 4'b1111, 0, 4'b1111, 1, 1, 1, 1);
        vecs[11] = mkv(4'b0000, 4'b1111, 0, 4'b0000, 0, 0, 0, 0);

        idle();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("reset_out_valid", 32'(bus.out_valid), 32'(0));
        chk("reset_in_ready", 32'(bus.in_ready), 32'(4'b1111));
        chk("reset_occupancy", 32'(occupancy), 32'(0));
        chk("reset_any_pending", 32'(any_pending), 32'(0));

        // Table-driven single-cycle vectors.
        for (int k = 0; k < 12; k++) begin
            logic [NF-1:0] exp_rdy;
            for (int c = 0; c < NF; c++) begin
                bus.in_valid[c] = vecs[k].iv[c];
                bus.in_entry[c] = mk_entry(k * 4 + c, 32'h2000 + k * 16 + c * 4);
                exp_rdy[c]      = (vecs[k].eocc[c] != OW'(DP));
            end
            bus.out_ready = vecs[k].orr;
            flush         = vecs[k].fl;
            tick();
            idle();
            $display("[TB] vec %0d: out_valid=%b occ=%h in_ready=%b", k, bus.out_valid, occupancy, bus.in_ready);
            chk($sformatf("vec%0d_out_valid", k), 32'(bus.out_valid), 32'(vecs[k].ev));
            chk($sformatf("vec%0d_occupancy", k), 32'(occupancy), 32'(vecs[k].eocc));
            chk($sformatf("vec%0d_in_ready", k), 32'(bus.in_ready), 32'(exp_rdy));
            chk($sformatf("vec%0d_any_pending", k), 32'(any_pending), 32'(vecs[k].ev != '0));
        end

        // Single push on channel 1 with no same-cycle bypass.
        bus.in_valid[1] = 1'b1;
        bus.in_entry[1] = mk_entry(5, 32'h100);
        #1;
        chk("single_no_bypass", 32'(bus.out_valid[1]), 32'(0));
        tick();
        idle();
        chk("single_out_valid", 32'(bus.out_valid[1]), 32'(1));
        chk("single_pc", 32'(bus.out_entry[1].pc), 32'h100);
        chk("single_tag", 32'(bus.out_entry[1].new_inst_tag), 32'(5));
        chk("single_occ", 32'(occupancy[1]), 32'(1));
        bus.out_ready[1] = 1'b1;
        tick();
        idle();
        chk("single_drained", 32'(bus.out_valid[1]), 32'(0));
        $display("[TB] single push ch1 done");

        // Fill channel 2 under back-pressure, then drain in order.
        for (int p = 1; p <= 4; p++) begin
            set_push(2, p);
            tick();
            if (p == 3) chk("fill_in_ready_full", 32'(bus.in_ready[2]), 32'(0));
        end
        idle();
        chk("fill_occ", 32'(occupancy[2]), 32'(DP));
        bus.out_ready[2] = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            chk($sformatf("fill_head_tag%0d", p), 32'(bus.out_entry[2].new_inst_tag), 32'(p));
            tick();
            if (p == 1) chk("fill_in_ready_after_pop", 32'(bus.in_ready[2]), 32'(1));
        end
        idle();
        chk("fill_4th_dropped", 32'(bus.out_valid[2]), 32'(0));
        $display("[TB] fill/back-pressure ch2 done");

        // Steady push+pop on channel 3 at occupancy 1; pointers wrap several times.
        set_push(3, 40);
        tick();
        for (int k = 1; k <= 10; k++) begin
            set_push(3, 40 + k);
            bus.out_ready[3] = 1'b1;
            chk($sformatf("stream_head%0d", k), 32'(bus.out_entry[3].new_inst_tag), 32'(40 + k - 1));
            tick();
            chk($sformatf("stream_occ%0d", k), 32'(occupancy[3]), 32'(1));
        end
        bus.in_valid[3] = 1'b0;
        tick();
        idle();
        chk("stream_drained", 32'(bus.out_valid[3]), 32'(0));
        $display("[TB] push+pop stream ch3 done");

        // Flush with push and pop active in the same cycle.
        set_push(0, 10);
        tick();
        set_push(0, 11);
        tick();
        chk("flush_pre_occ", 32'(occupancy[0]), 32'(2));
        set_push(0, 12);
        bus.out_ready[0] = 1'b1;
        flush = 1'b1;
        tick();
        idle();
        chk("flush_out_valid", 32'(bus.out_valid), 32'(0));
        chk("flush_occ", 32'(occupancy), 32'(0));
        chk("flush_in_ready", 32'(bus.in_ready), 32'(4'b1111));
        tick();
        chk("flush_push_absent", 32'(bus.out_valid[0]), 32'(0));
        $display("[TB] flush done");

        // Asynchronous reset in the middle of traffic, checked before any clock edge.
        set_push(0, 20);
        tick();
        set_push(0, 21);
        tick();
        idle();
        chk("areset_pre_occ", 32'(occupancy[0]), 32'(2));
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_out_valid", 32'(bus.out_valid), 32'(0));
        chk("areset_occ0", 32'(occupancy[0]), 32'(0));
        chk("areset_in_ready", 32'(bus.in_ready), 32'(4'b1111));
        chk("areset_any_pending", 32'(any_pending), 32'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick();
        chk("areset_post_occ", 32'(occupancy), 32'(0));
        $display("[TB] async reset done");

`ifdef FU_ISSUE_PERF_EN
        // Stall and issue counters on channel 1.
        for (int p = 0; p < DP + 7; p++) begin
            set_push(1, 30 + p);
            tick();
        end
        idle();
        chk("perf_stall7", stall_cnt[1], 32'd7);
        chk("perf_stall_other", stall_cnt[0], 32'd0);
        flush = 1'b1;
        tick();
        idle();
        chk("perf_stall_after_flush", stall_cnt[1], 32'd7);
        chk("perf_flush_occ", 32'(occupancy[1]), 32'(0));
        for (int p = 0; p < 3; p++) begin
            set_push(1, 50 + p);
            tick();
        end
        idle();
        bus.out_ready[1] = 1'b1;
        repeat (3) tick();
        idle();
        chk("perf_issue3", issue_cnt[1], 32'd3);
        chk("perf_stall_kept", stall_cnt[1], 32'd7);
        $display("[TB] perf counters done");
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fu_issue_queue.md
Name: fu_issue_queue

Overview:
- Per-functional-unit issue buffering stage between the reservation station (RS) and NUM_OF_FU functional units (FUs).
- Each channel is an independent DEPTH-entry FIFO with a valid/ready handshake on both sides. It decouples RS select timing from FU back-pressure.
- in_ready is registered-derived, so there is no combinational ready path from the FU back to the RS.
- A global flush empties all channels on branch mispredict or exception.

Parameters:
- NUM_OF_FU, 4, number of FU channels (>=1).
- DEPTH, 2, entries per channel FIFO (>=2, need not be a power of two).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of all channels
- in_valid  in  [NUM_OF_FU]  RS presents an instruction on channel i
- in_ready  out  [NUM_OF_FU]  channel i can accept
- in_entry  in  fu_issue_entry_t [NUM_OF_FU]  payload: src1_reg_val, src2_reg_val, dst_reg_addr, control, immediate, pc, new_inst_tag
- out_valid  out  [NUM_OF_FU]  head entry valid to FU i
- out_ready  in  [NUM_OF_FU]  FU i accepts head
- out_entry  out  fu_issue_entry_t [NUM_OF_FU]  head payload
- occupancy  out  [NUM_OF_FU] x $clog2(DEPTH+1)  entries held per channel
- any_pending  out  1  OR of all out_valid

Behaviour:
- Reset (async assert, sync deassert): all counts and pointers are 0, out_valid=0, occupancy=0, any_pending=0, in_ready=1.
  - Payload storage is not reset; out_entry is don't-care whenever out_valid=0.
- Push on channel i when in_valid[i] & in_ready[i] at a rising clk edge.
- Pop on channel i when out_valid[i] & out_ready[i] at a rising clk edge.
- in_ready[i] = (count[i] != DEPTH). It depends only on registered state and never on out_ready.
- out_valid[i] = (count[i] != 0). out_entry[i] = storage[rd_ptr[i]].
- Latency:
  - An entry pushed into an empty channel appears on out_valid the next cycle.
  - There is no same-cycle bypass.
- Simultaneous push and pop (channel not full): count is unchanged and both pointers advance.
- Full channel: in_ready=0, so a push cannot occur. A pop that cycle frees one slot, and in_ready=1 the next cycle.
- Pointers advance by 1 and wrap from DEPTH-1 to 0 by explicit compare (no modulo-by-power-of-two).
- Count updates: +1 on push only, -1 on pop only, unchanged otherwise. Count never exceeds DEPTH or goes below 0.
- Protocol rule: out_valid must stay high, with out_entry stable, until popped (except on flush). The RS may withdraw in_valid freely.
- Flush (sync, highest priority):
  - All counts and pointers go to 0 at the edge.
  - Pushes and pops in the flush cycle are discarded.
  - out_valid=0 the cycle after flush; in_ready stays a function of count.
- Channels are fully independent. There is no arbitration between them.
- occupancy[i] = count[i], registered.

Optional Feature:
- Macro FU_ISSUE_PERF_EN.
- When defined:
  - Add output stall_cnt [NUM_OF_FU] x 32. It increments each cycle in_valid[i] & !in_ready[i].
  - Add output issue_cnt [NUM_OF_FU] x 32. It increments on each pop.
  - Both counters saturate at all-ones, clear on reset only, and are unaffected by flush.
- When undefined: these ports and counters do not exist, and the functional behaviour is identical.

Decomposition:
- fu_issue_pkg holds:
  - typedef fu_issue_entry_t, a packed struct using `REG_VAL_WIDTH, `PHYSICAL_REG_NUM_WIDTH, `INST_ADDR_WIDTH, `ROB_SIZE_WIDTH and control_t;
  - function occ_width(DEPTH) = $clog2(DEPTH+1).
- Sub-module fu_issue_fifo: a single-channel DEPTH FIFO with flush and optional perf counters. It is instantiated NUM_OF_FU times in a generate loop. The top computes only any_pending.

Test Plan:
- Reset mid-traffic: fill channel 0 with 2 entries, assert reset_n=0 asynchronously -> out_valid=0, occupancy[0]=0, in_ready=1 immediately, without waiting for clk.
- Single push: channel 1 push of entry with pc=0x100, tag=5 -> out_valid[1]=1 next cycle with pc=0x100, tag=5; occupancy[1]=1.
- Fill and back-pressure: DEPTH=3, out_ready[2]=0, push 4 times -> in_ready[2]=0 after the 3rd push, 4th not accepted. Release out_ready -> entries pop in order (tags 1,2,3) and in_ready[2]=1 one cycle after the first pop.
- Simultaneous push+pop at occupancy 1 for 10 cycles with DEPTH=3 -> occupancy holds 1, order preserved, pointers wrap past index 2 correctly.
- Flush with push and pop active: channel 0 holds 2 entries, flush=1 with in_valid=1 and out_ready=1 -> next cycle all out_valid=0, occupancy=0, pushed entry absent.
- FU_ISSUE_PERF_EN: hold in_valid=1 on a full channel for 7 cycles -> stall_cnt=7. Flush -> stall_cnt still 7. 3 pops -> issue_cnt=3.
